// File: rtl/fxp_arb_pkg.sv
// Shared types and constants for the fixed-point add/sub arbiter.
package fxp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned MAX_W = 64;

  // Saturation constants, returned wide; callers truncate to their width.
  function automatic logic [MAX_W-1:0] max_pos(input int unsigned w);
    max_pos = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] max_neg(input int unsigned w);
    max_neg = MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/fxp_addsub_core.sv
// Combinational two's-complement add/sub with signed-overflow detect.
module fxp_addsub_core
  import fxp_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  output logic [WIDTH-1:0] sum_c,
  output logic             ovf_c
);

  logic [WIDTH-1:0] b_eff;

  // Sub is A + ~B + 1; overflow when effective operand signs agree but result differs.
  always_comb begin
    b_eff = (op_i == OP_SUB) ? ~b_i : b_i;
    sum_c = a_i + b_eff + WIDTH'(op_i);
    ovf_c = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/fxp_addsub_arbiter.sv
// Round-robin arbiter sharing one fxp add/sub datapath among NREQ requesters.
// Optional saturation of overflowed results is enabled by defining FXP_ARB_SAT_EN.
module fxp_addsub_arbiter
  import fxp_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_ovf
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, id_q, gnt_id_c;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic             gnt_any_c, fire_c;
  int unsigned      rr_idx;
  logic [WIDTH-1:0] sum_c, res_data_d;
  logic             ovf_c;
  logic             resp_valid_q, resp_ovf_q;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_data_q;

  fxp_addsub_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .sum_c (sum_c),
    .ovf_c (ovf_c)
  );

`ifdef FXP_ARB_SAT_EN
  assign res_data_d = !ovf_c ? sum_c :
                      (a_q[WIDTH-1] ? WIDTH'(max_neg(WIDTH)) : WIDTH'(max_pos(WIDTH)));
`else
  assign res_data_d = sum_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire_c) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant search starts one past the last winner; grant is masked outside IDLE and in reset.
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_id_c  = '0;
    rr_idx    = 0;
    req_ready = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = (32'(ptr_q) + k) % NREQ;
      if (!gnt_any_c && req_valid[IDW'(rr_idx)]) begin
        gnt_any_c = 1'b1;
        gnt_id_c  = IDW'(rr_idx);
      end
    end
    if (state_q == IDLE && gnt_any_c && !rst) req_ready[gnt_id_c] = 1'b1;
  end

  assign fire_c = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= IDW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && fire_c) begin
        a_q   <= req_a[gnt_id_c*WIDTH +: WIDTH];
        b_q   <= req_b[gnt_id_c*WIDTH +: WIDTH];
        op_q  <= req_op[gnt_id_c];
        id_q  <= gnt_id_c;
        ptr_q <= gnt_id_c;
      end
      if (state_q == EXEC) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= res_data_d;
        resp_ovf_q   <= ovf_c;
        resp_id_q    <= id_q;
      end
      if (state_q == HOLD && resp_ready) resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_ovf   = resp_ovf_q;

endmodule

// File: doc/fxp_addsub_arbiter.md
Name: fxp_addsub_arbiter

Overview:
- Shares one fixed-point two's-complement add/sub datapath between NREQ requesters, e.g. the ODE solver's derivative and state-update stages.
- Uses round-robin arbitration, a valid/ready request handshake, a registered result with overflow flag, and a response tagged by requester ID.
- Sits between solver stage controllers and the arithmetic unit.
- Processes one operation at a time; non-pipelined by design.

Parameters:
- WIDTH, 16, operand/result width in bits (fixed-point format is opaque to this block).
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID field.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high.
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_op  in  NREQ  0 = A+B, 1 = A-B.
- resp_valid  out  1  result valid.
- resp_ready  in  1  result consumed.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_data  out  WIDTH  result.
- resp_ovf  out  1  signed overflow of the result.

Behaviour:
- Reset (rst=1 at posedge, any state):
  - State goes to IDLE.
  - req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_ovf=0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Any in-flight operation is discarded with no response.
- States: IDLE, EXEC, HOLD.
- IDLE:
  - req_ready is combinational: the one-hot grant to the first requester with req_valid=1, searching from pointer+1 modulo NREQ.
  - On a handshake (valid & ready): latch A, B, op and ID; set pointer = granted ID; go to EXEC.
  - No valid requests: stay in IDLE.
- EXEC (1 cycle):
  - Drive latched operands into the datapath.
  - Register the result and overflow into resp_data/resp_ovf and the ID into resp_id.
  - Set resp_valid=1 and go to HOLD.
- HOLD:
  - resp_valid stays 1; resp_data, resp_ovf and resp_id are held stable.
  - On resp_ready=1: clear resp_valid and go to IDLE.
  - resp_data, resp_ovf and resp_id keep their last value after the clear.
- req_ready is 0 in EXEC and HOLD.
- Latency: handshake at edge t, then resp_valid=1 after edge t+1 (visible in cycle t+1..t+2 window).
- Minimum issue interval is 3 cycles.
- Requester contract: once req_valid is asserted it stays high with stable operands until accepted. The block does not check this.
- Arithmetic:
  - Sub computes A + ~B + 1, modulo 2^WIDTH.
  - resp_ovf = carry into MSB XOR carry out of MSB, equivalently both operand signs equal and result sign different, with B already inverted for sub.
  - B = most-negative in a sub is treated the same way: 0 - 0x8000 gives 0x8000 with ovf=1.
- Fairness:
  - A requester that is granted becomes lowest priority on the next arbitration.
  - With all requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0.
- A request that deasserts before being granted loses its place; there is no queueing.

Optional Feature:
- Macro: FXP_ARB_SAT_EN.
- Defined: when overflow occurs, resp_data saturates.
  - Positive overflow (operand sign 0) gives 0111..1.
  - Negative overflow gives 1000..0.
  - resp_ovf is still reported as 1.
- Undefined: resp_data is the wrapped modulo-2^WIDTH result; no saturation logic is built.

Decomposition:
- Package fxp_arb_pkg: state enum (IDLE, EXEC, HOLD); OP_ADD=0 and OP_SUB=1; helper functions for the saturation constants max_pos(WIDTH) and max_neg(WIDTH).
- Sub-module fxp_addsub_core: the combinational WIDTH-bit add/sub with overflow output. It is instantiated once in the arbiter and is separately testable.
- The round-robin grant logic stays inline in the arbiter.

Test Plan (WIDTH=16, NREQ=4):
- Single add: req 1 sends A=0x0100, B=0x0080, op=0.
  - Required: req_ready[1]=1 in the same cycle, then resp_valid two edges later with resp_id=1, data=0x0180, ovf=0.
- Overflow: req 0 sends 0x7FFF + 0x0001.
  - Without the macro: data=0x8000, ovf=1.
  - With FXP_ARB_SAT_EN: data=0x7FFF, ovf=1.
  - Also run 0x8000 - 0x0001: without the macro data=0x7FFF, ovf=1; with the macro data=0x8000.
- Round-robin: all 4 requesters held valid for 8 operations.
  - Required grant order: 0,1,2,3,0,1,2,3; each resp_id matches its grant; never more than one req_ready bit high.
- Backpressure: resp_ready held 0 for 5 cycles after resp_valid.
  - Required: resp_* stable for those 5 cycles, req_ready all 0, and the next grant occurs only in the cycle after the resp handshake.
- Reset mid-op: assert rst in the EXEC state with req 2 active.
  - Required: the next cycle has resp_valid=0 and all outputs 0; the first grant after reset goes to the lowest valid index (e.g. req 2 wins if it is the only one valid).
- Sub with zero result: 0x1234 - 0x1234.
  - Required: data=0x0000, ovf=0.
